stream_mux_rr: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered stream multiplexer; successor to the 2:1 combinational mux.

---
 rtl/stream_mux_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/stream_mux_rr.sv | 99 +++++++++
 tb/tb_stream_mux_rr.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} mux_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  logic [SELW-1:0] idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = SELW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant[grant_idx] = found;
  end

  assign any = |req;

endmodule

// File: rtl/stream_mux_rr.sv
// Round-robin N:1 stream multiplexer with one registered output stage.
// Define STREAM_MUX_LOCK_EN to keep the grant on one channel until its in_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic            load_en;
  logic            any_req;
  logic            xfer;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] arb_ptr;
  logic [WIDTH-1:0] sel_data;

`ifdef STREAM_MUX_LOCK_EN
  mux_state_t      state;
  logic [SELW-1:0] lock_ch;

  // While locked only the owning channel may request; others wait even if it is idle.
  assign req     = (state == LOCK) ? (in_valid & (N'(1) << lock_ch)) : in_valid;
  assign arb_ptr = (state == LOCK) ? lock_ch : ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      lock_ch <= '0;
    end else if (xfer) begin
      case (state)
        ARB: begin
          if (!in_last[gidx]) begin
            state   <= LOCK;
            lock_ch <= gidx;
          end
        end
        LOCK: begin
          if (in_last[gidx]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end
`else
  assign req     = in_valid;
  assign arb_ptr = ptr;
`endif

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req       (req),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any_req)
  );

  assign load_en  = ~out_valid | out_ready;
  assign xfer     = load_en & any_req & ~rst;
  assign in_ready = grant & {N{xfer}};
  assign sel_data = in_data[int'(gidx)*WIDTH +: WIDTH];

  // Output register stage: loads the granted beat, or empties when nothing is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= in_last[gidx];
        out_sel   <= gidx;
        ptr       <= SELW'(rr_next(int'(gidx), N));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: vector table, directed corner sequences and a random run
// checked against a cycle model and a per-channel scoreboard.
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    bit             rst;
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   l;
    bit             ordy;
    logic [N-1:0]   e_rdy;
    bit             e_v;
    logic [W-1:0]   e_d;
    int             e_s;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_sel;
  logic           out_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_err    = 0;

  beat_t src_q [N][$];
  beat_t sb_q  [N][$];
  logic [N-1:0] last_ready;

  // Reference model state, derived from the arbitration rules.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  bit           m_last  = 1'b0;
  int           m_sel   = 0;
  int           m_ptr   = 0;
  bit           m_lock  = 1'b0;
  int           m_lock_ch = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
`ifdef STREAM_MUX_LOCK_EN
    if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
    for (int off = 0; off < N; off++) begin
      int c;
      c = (m_ptr + off) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size() + sb_q[i].size();
    return s;
  endfunction

  task automatic cycle(input bit use_q);
    int g;
    beat_t b;
    logic [N-1:0] exp_rdy;
    if (use_q) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]       = (src_q[i].size() > 0);
        in_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0].d : '0;
        in_last[i]        = (src_q[i].size() > 0) ? src_q[i][0].l : 1'b0;
      end
    end
    @(negedge clk);
    g = m_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid === 1'b1 && out_ready && !rst) begin
      if (sb_q[out_sel].size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_extra: ch %0d data 0x%0h appeared, none expected", out_sel, out_data);
      end else begin
        b = sb_q[out_sel].pop_front();
        chk("sb_data", 32'(out_data), 32'(b.d));
        chk("sb_last", 32'(out_last), 32'(b.l));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i] && !rst) begin
        b.d = in_data[i*W +: W];
        b.l = in_last[i];
        sb_q[i].push_back(b);
        if (use_q && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
    end
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_sel = 0; m_ptr = 0;
      m_lock = 1'b0; m_lock_ch = 0;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_last  = in_last[g];
        m_sel   = g;
        m_ptr   = (g + 1) % N;
        if (!m_lock && !in_last[g]) begin
          m_lock = 1'b1;
          m_lock_ch = g;
        end else if (m_lock && in_last[g]) begin
          m_lock = 1'b0;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_last",  32'(out_last),  32'(m_last));
    chk("out_sel",   32'(out_sel),   32'(m_sel));
    if (rst) for (int i = 0; i < N; i++) sb_q[i].delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    vec_t  tbl [12];
    int    t4_exp [5];
    beat_t b;

    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;

    tbl[0]  = '{1, 4'b0000, 32'h0,        4'hF, 1, 4'b0000, 0, 8'h00, 0};
    tbl[1]  = '{0, 4'b0100, 32'h00110000, 4'hF, 1, 4'b0100, 1, 8'h11, 2};
    tbl[2]  = '{0, 4'b0100, 32'h00220000, 4'hF, 1, 4'b0100, 1, 8'h22, 2};
    tbl[3]  = '{0, 4'b0000, 32'h0,        4'hF, 1, 4'b0000, 0, 8'h22, 2};
    tbl[4]  = '{0, 4'b0000, 32'h0,        4'hF, 1, 4'b0000, 0, 8'h22, 2};
    tbl[5]  = '{1, 4'b0000, 32'h0,        4'hF, 1, 4'b0000, 0, 8'h00, 0};
    tbl[6]  = '{0, 4'b1111, 32'hD3C2B1A0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0};
    tbl[7]  = '{0, 4'b1111, 32'hD3C2B1A0, 4'hF, 1, 4'b0010, 1, 8'hB1, 1};
    tbl[8]  = '{0, 4'b1111, 32'hD3C2B1A0, 4'hF, 1, 4'b0100, 1, 8'hC2, 2};
    tbl[9]  = '{0, 4'b1111, 32'hD3C2B1A0, 4'hF, 1, 4'b1000, 1, 8'hD3, 3};
    tbl[10] = '{0, 4'b1111, 32'hD3C2B1A0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0};
    tbl[11] = '{0, 4'b1111, 32'hD3C2B1A0, 4'hF, 1, 4'b0010, 1, 8'hB1, 1};

    for (int r = 0; r < 12; r++) begin
      rst = tbl[r].rst; in_valid = tbl[r].v; in_data = tbl[r].d;
      in_last = tbl[r].l; out_ready = tbl[r].ordy;
      cycle(1'b0);
      chk($sformatf("tbl%0d_rdy", r),   32'(last_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_valid", r), 32'(out_valid),  32'(tbl[r].e_v));
      chk($sformatf("tbl%0d_data", r),  32'(out_data),   32'(tbl[r].e_d));
      chk($sformatf("tbl%0d_sel", r),   32'(out_sel),    32'(tbl[r].e_s));
    end

    // Back-pressure: held beat must stay put and no channel may be accepted.
    rst = 1'b1; cycle(1'b1);
    chk("t3_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    b.d = 8'hA5; b.l = 1'b1; src_q[0].push_back(b);
    cycle(1'b1);
    chk("t3_first", 32'(out_data), 32'hA5);
    b.d = 8'h5A; b.l = 1'b1; src_q[1].push_back(b);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      chk("t3_hold_rdy",   32'(last_ready), 32'd0);
      chk("t3_hold_data",  32'(out_data),   32'hA5);
      chk("t3_hold_valid", 32'(out_valid),  32'd1);
    end
    out_ready = 1'b1;
    cycle(1'b1);
    chk("t3_release_rdy",  32'(last_ready), 32'b0010);
    chk("t3_release_data", 32'(out_data),   32'h5A);

    // Packet from ch1 competing with single beats on ch0 and ch2.
`ifdef STREAM_MUX_LOCK_EN
    t4_exp = '{1, 1, 1, 2, 0};
`else
    t4_exp = '{1, 2, 0, 1, 1};
`endif
    rst = 1'b1; cycle(1'b1);
    rst = 1'b0;
    b.d = 8'h00; b.l = 1'b1; src_q[0].push_back(b);
    cycle(1'b1);
    chk("t4_pre_sel", 32'(out_sel), 32'd0);
    b.d = 8'h31; b.l = 1'b0; src_q[1].push_back(b);
    b.d = 8'h32; b.l = 1'b0; src_q[1].push_back(b);
    b.d = 8'h33; b.l = 1'b1; src_q[1].push_back(b);
    b.d = 8'h01; b.l = 1'b1; src_q[0].push_back(b);
    b.d = 8'h21; b.l = 1'b1; src_q[2].push_back(b);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1);
      chk($sformatf("t4_sel%0d", k), 32'(out_sel), 32'(t4_exp[k]));
    end

    // Reset in the middle of a packet drops it and restarts arbitration at ch0.
    rst = 1'b1; cycle(1'b1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b.d = 8'(8'h41 + k); b.l = (k == 3); src_q[3].push_back(b);
    end
    cycle(1'b1);
    cycle(1'b1);
    chk("t5_beat2", 32'(out_data), 32'h42);
    rst = 1'b1;
    cycle(1'b1);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_sel",   32'(out_sel),   32'd0);
    src_q[3].delete();
    rst = 1'b0;
    b.d = 8'h77; b.l = 1'b1; src_q[0].push_back(b);
    b.d = 8'h88; b.l = 1'b1; src_q[3].push_back(b);
    cycle(1'b1);
    chk("t5_first_sel", 32'(out_sel), 32'd0);
    cycle(1'b1);
    chk("t5_second_sel", 32'(out_sel), 32'd3);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          b.d = 8'($urandom);
          b.l = ($urandom_range(0, 2) == 0);
          src_q[i].push_back(b);
        end
      end
      cycle(1'b1);
    end

    out_ready = 1'b1;
    for (int c = 0; c < 200 && (pending() > 0 || out_valid); c++) cycle(1'b1);
    chk("drain_pending", 32'(pending()), 32'd0);
    chk("drain_valid",   32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
